// File: rtl/present_ks_ctrl.sv
// present_ks_ctrl: PRESENT-80 key schedule sequencer streaming round keys K1..K32 over valid/ready.
// Define PRESENT_KS_ERR_EN to add the start_err output (start seen while busy).
module present_ks_ctrl #(
   parameter int NROUNDS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [79:0] key_in,
   output logic        rk_valid,
   input  logic        rk_ready,
   output logic [63:0] rk_data,
   output logic [5:0]  rk_idx,
   output logic        busy,
   output logic        done
`ifdef PRESENT_KS_ERR_EN
   ,output logic       start_err
`endif
);
   localparam logic [1:0]  S_IDLE = 2'd0;
   localparam logic [1:0]  S_RUN  = 2'd1;
   localparam logic [1:0]  S_DONE = 2'd2;
   localparam logic [5:0]  LAST   = 6'(NROUNDS);
   // S-box packed as a 16-entry nibble table, entry x at bits [4x+3:4x]
   localparam logic [63:0] SBOX   = 64'h2174_8FE3_DA09_B65C;

   logic [1:0]  state_q, state_d;
   logic [79:0] kreg_q, kreg_d, rot, upd;
   logic [5:0]  round_q, round_d;
   logic        valid_q, valid_d, busy_q, busy_d, done_q, done_d;
   logic        accept;

   // kreg[79] holds key bit 0 (the MSB), so the round key is kreg[79:16]
   always_comb begin
      rot = {kreg_q[18:0], kreg_q[79:19]};
      upd = rot;
      upd[79:76] = SBOX[{rot[79:76], 2'b00} +: 4];
      upd[19:15] = rot[19:15] ^ round_q[4:0];
      accept = (state_q == S_RUN) && rk_ready;
      state_d = state_q;
      kreg_d = kreg_q;
      round_d = round_q;
      if (state_q == S_IDLE && start) begin
         state_d = S_RUN;
         kreg_d = key_in;
         round_d = 6'd1;
      end else if (accept && round_q < LAST) begin
         kreg_d = upd;
         round_d = round_q + 6'd1;
      end else if (accept) begin
         state_d = S_DONE;
      end else if (state_q == S_DONE) begin
         state_d = S_IDLE;
      end
      valid_d = state_d == S_RUN;
      busy_d = state_d != S_IDLE;
      done_d = state_d == S_DONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         kreg_q <= '0;
         round_q <= '0;
         valid_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         kreg_q <= kreg_d;
         round_q <= round_d;
         valid_q <= valid_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign rk_valid = valid_q;
   assign rk_data = kreg_q[79:16];
   assign rk_idx = round_q;
   assign busy = busy_q;
   assign done = done_q;

`ifdef PRESENT_KS_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = start && (state_q != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else err_q <= err_d;
   end

   assign start_err = err_q;
`endif
endmodule

// File: tb/tb_present_ks_ctrl.sv
// tb_present_ks_ctrl: directed vector table plus multi-cycle sequences for present_ks_ctrl.
// Expected round keys come from a bit-serial model written in the MSB-first (bit 0 = MSB) notation.
module tb_present_ks_ctrl;
   localparam int NROUNDS = 32;
   localparam logic [3:0] SBT [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   logic        clk, rst_n, start, rk_ready, rk_valid, busy, done;
   logic [79:0] key_in;
   logic [63:0] rk_data;
   logic [5:0]  rk_idx;
`ifdef PRESENT_KS_ERR_EN
   logic        start_err;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [79:0] kkey;
   logic [63:0] kexp [1:NROUNDS];

   typedef struct {
      logic        start;
      logic        ready;
      logic [79:0] key;
      logic        ev;
      logic [63:0] ed;
      logic [5:0]  ei;
      logic        eb;
      logic        edn;
   } vec_t;
   vec_t tv [5];

   present_ks_ctrl #(.NROUNDS(NROUNDS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
      .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
      .rk_idx(rk_idx), .busy(busy), .done(done)
`ifdef PRESENT_KS_ERR_EN
      , .start_err(start_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // key bit i in MSB-first notation lives at vector position 79-i
   function automatic logic [79:0] upd_m(input logic [79:0] k, input logic [4:0] c);
      logic [79:0] r;
      for (int i = 0; i < 80; i++) r[79-i] = k[79-((i+61)%80)];
      r[79:76] = SBT[r[79:76]];
      r[19:15] = r[19:15] ^ c;
      return r;
   endfunction

   task automatic build_k(input logic [79:0] key);
      logic [79:0] kk;
      kk = key;
      kexp[1] = kk[79:16];
      for (int r = 1; r < NROUNDS; r++) begin
         kk = upd_m(kk, 5'(r));
         kexp[r+1] = kk[79:16];
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_valid"}, 64'(rk_valid), 0);
      chk({nm, "_busy"}, 64'(busy), 0);
      chk({nm, "_done"}, 64'(done), 0);
   endtask

   task automatic chk_zero(input string nm);
      chk_idle(nm);
      chk({nm, "_data"}, rk_data, 0);
      chk({nm, "_idx"}, 64'(rk_idx), 0);
`ifdef PRESENT_KS_ERR_EN
      chk({nm, "_err"}, 64'(start_err), 0);
`endif
   endtask

   task automatic run_sched(input bit stall, input bit inj);
      int e, cyc;
      bit injd, s;
      logic rdy;
      start = 1'b1;
      key_in = kkey;
      rk_ready = 1'b0;
      step();
      start = 1'b0;
      chk("k1_valid", 64'(rk_valid), 1);
      chk("k1_idx", 64'(rk_idx), 1);
      chk("k1_data", rk_data, kexp[1]);
      e = 1;
      cyc = 0;
      injd = 1'b0;
      while (e <= NROUNDS && cyc < 2000) begin
         rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         s = inj && !injd && e == 10;
         injd = injd | s;
         rk_ready = rdy;
         start = s;
         key_in = s ? ~kkey : kkey;
         step();
         cyc++;
         start = 1'b0;
`ifdef PRESENT_KS_ERR_EN
         chk("start_err", 64'(start_err), 64'(s));
`endif
         if (rdy) e++;
         if (e <= NROUNDS) begin
            chk("run_valid", 64'(rk_valid), 1);
            chk("run_idx", 64'(rk_idx), 64'(e));
            chk("run_data", rk_data, kexp[e]);
            chk("run_busy", 64'(busy), 1);
            chk("run_done", 64'(done), 0);
         end else begin
            chk("done_pulse", 64'(done), 1);
            chk("done_valid", 64'(rk_valid), 0);
            chk("done_busy", 64'(busy), 1);
         end
      end
      rk_ready = 1'b0;
      if (e <= NROUNDS) begin
         n_vec++;
         n_err++;
         $display("FAIL timeout: reached idx %0d, required done after %0d", e, NROUNDS);
      end
      if (inj) chk("inj_done", 64'(injd), 1);
   endtask

   initial begin
      tv[0] = '{start: 1'b0, ready: 1'b0, key: '0, ev: 1'b0, ed: 64'h0, ei: 6'd0, eb: 1'b0, edn: 1'b0};
      tv[1] = '{start: 1'b1, ready: 1'b0, key: '0, ev: 1'b1, ed: 64'h0, ei: 6'd1, eb: 1'b1, edn: 1'b0};
      tv[2] = '{start: 1'b0, ready: 1'b0, key: '0, ev: 1'b1, ed: 64'h0, ei: 6'd1, eb: 1'b1, edn: 1'b0};
      tv[3] = '{start: 1'b0, ready: 1'b1, key: '0, ev: 1'b1, ed: 64'hC000_0000_0000_0000, ei: 6'd2, eb: 1'b1, edn: 1'b0};
      tv[4] = '{start: 1'b0, ready: 1'b0, key: '0, ev: 1'b1, ed: 64'hC000_0000_0000_0000, ei: 6'd2, eb: 1'b1, edn: 1'b0};
      kkey = 80'h0123_4567_89AB_CDEF_FEDC;
      build_k(kkey);
      rst_n = 1'b0;
      start = 1'b0;
      rk_ready = 1'b0;
      key_in = '0;
      #12;
      chk_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         start = tv[i].start;
         rk_ready = tv[i].ready;
         key_in = tv[i].key;
         step();
         chk($sformatf("tv%0d_valid", i), 64'(rk_valid), 64'(tv[i].ev));
         chk($sformatf("tv%0d_data", i), rk_data, tv[i].ed);
         chk($sformatf("tv%0d_idx", i), 64'(rk_idx), 64'(tv[i].ei));
         chk($sformatf("tv%0d_busy", i), 64'(busy), 64'(tv[i].eb));
         chk($sformatf("tv%0d_done", i), 64'(done), 64'(tv[i].edn));
      end
      start = 1'b0;
      rk_ready = 1'b0;
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      run_sched(1'b0, 1'b0);
      step();
      chk_idle("full_after");
      run_sched(1'b1, 1'b0);
      step();
      chk_idle("stall_after");
      run_sched(1'b0, 1'b1);
      step();
      chk_idle("inj_after");
`ifdef PRESENT_KS_ERR_EN
      chk("inj_after_err", 64'(start_err), 0);
`endif
      start = 1'b1;
      key_in = kkey;
      step();
      start = 1'b0;
      rk_ready = 1'b1;
      for (int i = 0; i < 16; i++) step();
      chk("mid_idx", 64'(rk_idx), 17);
      chk("mid_data", rk_data, kexp[17]);
      #2 rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      rk_ready = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      run_sched(1'b0, 1'b0);
      start = 1'b1;
      key_in = kkey;
      step();
      start = 1'b0;
      chk_idle("start_in_done");
`ifdef PRESENT_KS_ERR_EN
      chk("start_in_done_err", 64'(start_err), 1);
`endif
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_valid", 64'(rk_valid), 1);
      chk("restart_idx", 64'(rk_idx), 1);
      chk("restart_data", rk_data, kexp[1]);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
